pcpi_mul_arbiter: RTL and testbench

Two-requester arbiter that shares one PCPI multiplier between two PCPI masters, e.g. the CPU core and the crypto/control sequencer. It sits between both masters' PCPI buses and the single multiplier instance.
- Round-robin grant; the grant is held for a whole multiply.
- Holds `wait` towards a stalled master so that master's PCPI timeout never fires.
- Provides a watchdog that releases a hung grant.

---
 rtl/pcpi_mul_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pcpi_mul_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcpi_mul_arbiter.sv
// pcpi_mul_arbiter: shares one PCPI multiplier between two PCPI masters.
// Round-robin grant is held for a whole multiply. Stalled masters see wait
// high so their own PCPI timeouts stay quiet. A watchdog aborts a grant that
// the multiplier never answers.
module pcpi_mul_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req0_valid,
    input  logic [31:0] req0_insn,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    output logic        req0_wr,
    output logic [31:0] req0_rd,
    output logic        req0_wait,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_insn,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    output logic        req1_wr,
    output logic [31:0] req1_rd,
    output logic        req1_wait,
    output logic        req1_ready,
    output logic        cop_valid,
    output logic [31:0] cop_insn,
    output logic [31:0] cop_rs1,
    output logic [31:0] cop_rs2,
    input  logic        cop_wr,
    input  logic [31:0] cop_rd,
    input  logic        cop_wait,
    input  logic        cop_ready,
    output logic        err_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic             gnt;
    logic             gnt_nxt;
    logic             last;
    logic             last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       aborted;
    logic [1:0]       aborted_nxt;
    logic [1:0]       valid_in;
    logic [1:0]       is_mul;
    logic [1:0]       eligible;
    logic [1:0]       wait_nxt;
    logic             take_resp;
    logic             do_abort;
    logic             served;
    logic             unused_cop_wait;

    // The multiplier's own wait is not needed: the arbiter stalls masters itself.
    assign unused_cop_wait = cop_wait;

    assign valid_in = {req1_valid, req0_valid};

    assign is_mul[0] = req0_valid && (req0_insn[6:0] == 7'b0110011) &&
                       (req0_insn[31:25] == 7'b0000001) && !req0_insn[14];
    assign is_mul[1] = req1_valid && (req1_insn[6:0] == 7'b0110011) &&
                       (req1_insn[31:25] == 7'b0000001) && !req1_insn[14];

    // An aborted master may not be granted again until it drops its valid.
    assign eligible = is_mul & ~aborted;

    // Next-state logic: grant selection, multiply tracking and watchdog.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        last_nxt  = last;
        cnt_nxt   = cnt;
        take_resp = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != 2'b00) begin
                    gnt_nxt   = (eligible == 2'b11) ? ~last : eligible[1];
                    last_nxt  = (eligible == 2'b11) ? ~last : eligible[1];
                    cnt_nxt   = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = cnt + 1'b1;
                if (cop_ready) begin
                    take_resp = 1'b1;
                    state_nxt = RESP;
                end else if (!valid_in[gnt]) begin
                    state_nxt = GAP;
                end else if (cnt == CNT_LAST) begin
                    do_abort  = 1'b1;
                    state_nxt = GAP;
                end
            end
            RESP:    state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Abort flags and wait: the served master loses wait in RESP and GAP.
    always_comb begin
        served         = (state == RESP) || (state_nxt == RESP);
        aborted_nxt[0] = valid_in[0] & (aborted[0] | (do_abort & ~gnt));
        aborted_nxt[1] = valid_in[1] & (aborted[1] | (do_abort & gnt));
        wait_nxt[0]    = is_mul[0] & ~aborted_nxt[0] & ~(served & ~gnt);
        wait_nxt[1]    = is_mul[1] & ~aborted_nxt[1] & ~(served & gnt);
    end

    // Multiplier-side bus follows the granted master only while BUSY.
    always_comb begin
        cop_valid = 1'b0;
        cop_insn  = '0;
        cop_rs1   = '0;
        cop_rs2   = '0;
        if (state == BUSY) begin
            cop_valid = 1'b1;
            cop_insn  = gnt ? req1_insn : req0_insn;
            cop_rs1   = gnt ? req1_rs1  : req0_rs1;
            cop_rs2   = gnt ? req1_rs2  : req0_rs2;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            cnt     <= '0;
            aborted <= 2'b00;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            last    <= last_nxt;
            cnt     <= cnt_nxt;
            aborted <= aborted_nxt;
        end
    end

    // Registered master-side responses, wait flags and the watchdog pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_wr     <= 1'b0;
            req1_wr     <= 1'b0;
            req0_rd     <= '0;
            req1_rd     <= '0;
            req0_wait   <= 1'b0;
            req1_wait   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            req0_ready  <= take_resp & ~gnt;
            req1_ready  <= take_resp & gnt;
            req0_wr     <= take_resp & ~gnt & cop_wr;
            req1_wr     <= take_resp & gnt & cop_wr;
            if (take_resp && !gnt) begin
                req0_rd <= cop_rd;
            end
            if (take_resp && gnt) begin
                req1_rd <= cop_rd;
            end
            req0_wait   <= wait_nxt[0];
            req1_wait   <= wait_nxt[1];
            err_timeout <= do_abort;
        end
    end

endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// tb_pcpi_mul_arbiter: directed bench for the two-master PCPI multiplier
// arbiter, with a small fixed-latency multiplier model on the cop side.
module tb_pcpi_mul_arbiter;

    localparam logic [31:0] INSN_MUL   = 32'h02B50533;
    localparam logic [31:0] INSN_MULHU = 32'h02B53533;
    localparam logic [31:0] INSN_ADD   = 32'h00B50533;
    localparam int          MUL_LAT    = 3;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;

    logic        req0_valid = 1'b0;
    logic [31:0] req0_insn  = '0;
    logic [31:0] req0_rs1   = '0;
    logic [31:0] req0_rs2   = '0;
    logic        req0_wr;
    logic [31:0] req0_rd;
    logic        req0_wait;
    logic        req0_ready;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_insn  = '0;
    logic [31:0] req1_rs1   = '0;
    logic [31:0] req1_rs2   = '0;
    logic        req1_wr;
    logic [31:0] req1_rd;
    logic        req1_wait;
    logic        req1_ready;
    logic        cop_valid;
    logic [31:0] cop_insn;
    logic [31:0] cop_rs1;
    logic [31:0] cop_rs2;
    logic        cop_wr;
    logic [31:0] cop_rd;
    logic        cop_wait;
    logic        cop_ready;
    logic        err_timeout;

    logic        mul_enable = 1'b1;
    int          mcnt;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] prod;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] rr_rs2 [4] = '{32'd4, 32'd50, 32'd4, 32'd50};
    logic [31:0] rr_rd  [4] = '{32'd20, 32'd300, 32'd20, 32'd300};
    logic        rr_gnt [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    pcpi_mul_arbiter #(
        .TIMEOUT_CYCLES(255),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .req0_valid(req0_valid),
        .req0_insn(req0_insn),
        .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2),
        .req0_wr(req0_wr),
        .req0_rd(req0_rd),
        .req0_wait(req0_wait),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_insn(req1_insn),
        .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2),
        .req1_wr(req1_wr),
        .req1_rd(req1_rd),
        .req1_wait(req1_wait),
        .req1_ready(req1_ready),
        .cop_valid(cop_valid),
        .cop_insn(cop_insn),
        .cop_rs1(cop_rs1),
        .cop_rs2(cop_rs2),
        .cop_wr(cop_wr),
        .cop_rd(cop_rd),
        .cop_wait(cop_wait),
        .cop_ready(cop_ready),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Multiplier operand extension by funct3 (MUL/MULH/MULHSU/MULHU).
    always_comb begin
        ax = {32'b0, cop_rs1};
        bx = {32'b0, cop_rs2};
        if (cop_insn[13:12] == 2'd1 || cop_insn[13:12] == 2'd2) ax = {{32{cop_rs1[31]}}, cop_rs1};
        if (cop_insn[13:12] == 2'd1) bx = {{32{cop_rs2[31]}}, cop_rs2};
        prod = ax * bx;
    end

    assign cop_wait = cop_valid & ~cop_ready;

    // Fixed-latency multiplier model; never answers while mul_enable is low.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mcnt      <= 0;
            cop_ready <= 1'b0;
            cop_wr    <= 1'b0;
            cop_rd    <= '0;
        end else begin
            cop_ready <= 1'b0;
            cop_wr    <= 1'b0;
            if (!cop_valid) begin
                mcnt <= 0;
            end else if (mul_enable && !cop_ready) begin
                if (mcnt == MUL_LAT - 1) begin
                    cop_ready <= 1'b1;
                    cop_wr    <= 1'b1;
                    cop_rd    <= (cop_insn[13:12] == 2'd0) ? prod[31:0] : prod[63:32];
                    mcnt      <= 0;
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic v, input logic [31:0] insn,
                                 input logic [31:0] rs1, input logic [31:0] rs2);
        if (m == 0) begin
            req0_valid = v;
            req0_insn  = insn;
            req0_rs1   = rs1;
            req0_rs2   = rs2;
        end else begin
            req1_valid = v;
            req1_insn  = insn;
            req1_rs1   = rs1;
            req1_rs2   = rs2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic waitCopReady(input string tag);
        int n = 0;
        while (cop_ready !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(cop_ready), 32'd1);
    endtask

    task automatic waitCopValid(input string tag);
        int n = 0;
        while (cop_valid !== 1'b1 && n < 50) begin
            step(1);
            n++;
        end
        checkOutput(tag, 32'(cop_valid), 32'd1);
    endtask

    // Runaway guard: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Directed sequence.
    initial begin
        // Reset values
        resetn = 1'b0;
        step(2);
        checkOutput("rst_cop_valid", 32'(cop_valid), 32'd0);
        checkOutput("rst_req0_wait", 32'(req0_wait), 32'd0);
        checkOutput("rst_req0_rd", req0_rd, 32'd0);
        checkOutput("rst_err", 32'(err_timeout), 32'd0);
        resetn = 1'b1;
        step(1);

        // Single MUL from master 0, 7*6
        $display("[TB] single MUL from master 0");
        applyStimulus(0, 1'b1, INSN_MUL, 32'd7, 32'd6);
        checkOutput("t1_idle_cop_valid", 32'(cop_valid), 32'd0);
        step(1);
        checkOutput("t1_busy_cop_valid", 32'(cop_valid), 32'd1);
        checkOutput("t1_cop_insn", cop_insn, INSN_MUL);
        checkOutput("t1_cop_rs1", cop_rs1, 32'd7);
        checkOutput("t1_req0_wait", 32'(req0_wait), 32'd1);
        checkOutput("t1_req1_wait", 32'(req1_wait), 32'd0);
        waitCopReady("t1_cop_ready");
        checkOutput("t1_ready_not_early", 32'(req0_ready), 32'd0);
        step(1);
        checkOutput("t1_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("t1_req0_wr", 32'(req0_wr), 32'd1);
        checkOutput("t1_req0_rd", req0_rd, 32'd42);
        checkOutput("t1_resp_wait", 32'(req0_wait), 32'd0);
        checkOutput("t1_resp_cop_valid", 32'(cop_valid), 32'd0);
        checkOutput("t1_req1_ready", 32'(req1_ready), 32'd0);
        applyStimulus(0, 1'b0, '0, '0, '0);
        step(1);
        checkOutput("t1_gap_ready", 32'(req0_ready), 32'd0);
        checkOutput("t1_gap_wr", 32'(req0_wr), 32'd0);
        checkOutput("t1_rd_hold", req0_rd, 32'd42);
        checkOutput("t1_req1_wait_end", 32'(req1_wait), 32'd0);
        step(1);

        // Simultaneous MULHU after reset: master 0 first, then master 1
        $display("[TB] simultaneous MULHU");
        resetn = 1'b0;
        step(1);
        resetn = 1'b1;
        step(1);
        applyStimulus(0, 1'b1, INSN_MULHU, 32'h8000_0000, 32'd4);
        applyStimulus(1, 1'b1, INSN_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1);
        checkOutput("t2_first_gnt_rs1", cop_rs1, 32'h8000_0000);
        checkOutput("t2_req0_wait", 32'(req0_wait), 32'd1);
        checkOutput("t2_req1_wait_a", 32'(req1_wait), 32'd1);
        waitCopReady("t2_cop_ready0");
        step(1);
        checkOutput("t2_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("t2_req0_rd", req0_rd, 32'd2);
        checkOutput("t2_req1_ready_none", 32'(req1_ready), 32'd0);
        checkOutput("t2_req1_wait_b", 32'(req1_wait), 32'd1);
        applyStimulus(0, 1'b0, '0, '0, '0);
        step(1);
        checkOutput("t2_req1_wait_gap", 32'(req1_wait), 32'd1);
        checkOutput("t2_gap_cop_valid", 32'(cop_valid), 32'd0);
        step(1);
        checkOutput("t2_req1_wait_idle", 32'(req1_wait), 32'd1);
        step(1);
        checkOutput("t2_second_cop_valid", 32'(cop_valid), 32'd1);
        checkOutput("t2_second_gnt_rs1", cop_rs1, 32'hFFFF_FFFF);
        waitCopReady("t2_cop_ready1");
        checkOutput("t2_req1_wait_c", 32'(req1_wait), 32'd1);
        step(1);
        checkOutput("t2_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("t2_req1_wr", 32'(req1_wr), 32'd1);
        checkOutput("t2_req1_rd", req1_rd, 32'hFFFF_FFFE);
        checkOutput("t2_req1_wait_resp", 32'(req1_wait), 32'd0);
        checkOutput("t2_req0_ready_none", 32'(req0_ready), 32'd0);
        checkOutput("t2_req0_rd_hold", req0_rd, 32'd2);
        applyStimulus(1, 1'b0, '0, '0, '0);
        step(1);

        // Repeated simultaneous requests alternate 0,1,0,1
        $display("[TB] round-robin alternation");
        applyStimulus(0, 1'b1, INSN_MUL, 32'd5, 32'd4);
        applyStimulus(1, 1'b1, INSN_MUL, 32'd6, 32'd50);
        for (int r = 0; r < 4; r++) begin
            waitCopValid("t3_cop_valid");
            checkOutput("t3_grant_rs2", cop_rs2, rr_rs2[r]);
            checkOutput("t3_other_wait", 32'(rr_gnt[r] ? req0_wait : req1_wait), 32'd1);
            waitCopReady("t3_cop_ready");
            step(1);
            checkOutput("t3_gnt_ready", 32'(rr_gnt[r] ? req1_ready : req0_ready), 32'd1);
            checkOutput("t3_other_ready", 32'(rr_gnt[r] ? req0_ready : req1_ready), 32'd0);
            checkOutput("t3_gnt_rd", rr_gnt[r] ? req1_rd : req0_rd, rr_rd[r]);
            applyStimulus(rr_gnt[r] ? 1 : 0, 1'b0, '0, '0, '0);
            step(1);
            if (r < 3) begin
                if (rr_gnt[r]) applyStimulus(1, 1'b1, INSN_MUL, 32'd6, 32'd50);
                else           applyStimulus(0, 1'b1, INSN_MUL, 32'd5, 32'd4);
            end else begin
                applyStimulus(0, 1'b0, '0, '0, '0);
            end
        end
        step(1);

        // Non-mul instruction is ignored
        $display("[TB] non-mul instruction");
        applyStimulus(1, 1'b1, INSN_ADD, 32'd3, 32'd4);
        step(3);
        checkOutput("t4_cop_valid", 32'(cop_valid), 32'd0);
        checkOutput("t4_req1_wait", 32'(req1_wait), 32'd0);
        checkOutput("t4_req1_ready", 32'(req1_ready), 32'd0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        step(1);

        // Watchdog abort after 255 BUSY cycles; master 1 is then served
        $display("[TB] watchdog abort");
        mul_enable = 1'b0;
        applyStimulus(0, 1'b1, INSN_MUL, 32'd11, 32'd12);
        step(1);
        checkOutput("t5_busy", 32'(cop_valid), 32'd1);
        step(98);
        applyStimulus(1, 1'b1, INSN_MUL, 32'd13, 32'd2);
        step(155);
        checkOutput("t5_c254_err", 32'(err_timeout), 32'd0);
        checkOutput("t5_c254_req0_wait", 32'(req0_wait), 32'd1);
        checkOutput("t5_c254_req1_wait", 32'(req1_wait), 32'd1);
        step(1);
        checkOutput("t5_c255_err", 32'(err_timeout), 32'd0);
        checkOutput("t5_c255_busy", 32'(cop_valid), 32'd1);
        step(1);
        checkOutput("t5_err_pulse", 32'(err_timeout), 32'd1);
        checkOutput("t5_abort_cop_valid", 32'(cop_valid), 32'd0);
        checkOutput("t5_no_ready", 32'(req0_ready), 32'd0);
        checkOutput("t5_wait_drop", 32'(req0_wait), 32'd0);
        checkOutput("t5_req1_still_wait", 32'(req1_wait), 32'd1);
        mul_enable = 1'b1;
        step(1);
        checkOutput("t5_err_single", 32'(err_timeout), 32'd0);
        step(1);
        checkOutput("t5_req1_grant", cop_rs1, 32'd13);
        checkOutput("t5_req0_wait_held0", 32'(req0_wait), 32'd0);
        waitCopReady("t5_cop_ready");
        step(1);
        checkOutput("t5_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("t5_req1_rd", req1_rd, 32'd26);
        checkOutput("t5_req0_ready_none", 32'(req0_ready), 32'd0);
        applyStimulus(0, 1'b0, '0, '0, '0);
        applyStimulus(1, 1'b0, '0, '0, '0);
        step(2);

        // Reset mid-multiply, then a fresh request completes
        $display("[TB] reset mid-multiply");
        applyStimulus(0, 1'b1, INSN_MUL, 32'd9, 32'd9);
        step(1);
        checkOutput("t6_regrant_after_abort", 32'(cop_valid), 32'd1);
        checkOutput("t6_cop_rs1", cop_rs1, 32'd9);
        step(1);
        resetn = 1'b0;
        #1;
        checkOutput("t6_async_cop_valid", 32'(cop_valid), 32'd0);
        checkOutput("t6_async_cop_rs1", cop_rs1, 32'd0);
        checkOutput("t6_async_req0_wait", 32'(req0_wait), 32'd0);
        checkOutput("t6_async_req0_rd", req0_rd, 32'd0);
        checkOutput("t6_async_req1_rd", req1_rd, 32'd0);
        step(1);
        checkOutput("t6_held_cop_valid", 32'(cop_valid), 32'd0);
        resetn = 1'b1;
        step(1);
        checkOutput("t6_post_busy", 32'(cop_valid), 32'd1);
        waitCopReady("t6_cop_ready");
        step(1);
        checkOutput("t6_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("t6_req0_rd", req0_rd, 32'd81);
        applyStimulus(0, 1'b0, '0, '0, '0);
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
